// File: rtl/issue_wakeup_pipeline_pkg.sv
// Shared scheduler definitions for the issue/wakeup pipeline: per-stage payload,
// port-class latencies and the lane offsets of each port class.
package issue_wakeup_pipeline_pkg;

  localparam int ENTRY_NUM = 16;
  localparam int PTR_W     = $clog2(ENTRY_NUM);
  localparam int TAG_W     = 7;

  localparam int INT_W   = 2;
  localparam int COMP_W  = 1;
  localparam int LOAD_W  = 1;
  localparam int STORE_W = 1;
  localparam int ISSUE_W = INT_W + COMP_W + LOAD_W + STORE_W;

  localparam int COMP_LAT = 3;
  localparam int LOAD_LAT = 2;

  // Lane order on every per-port vector: int, complex, load, store.
  localparam int INT_BASE   = 0;
  localparam int COMP_BASE  = INT_BASE + INT_W;
  localparam int LOAD_BASE  = COMP_BASE + COMP_W;
  localparam int STORE_BASE = LOAD_BASE + LOAD_W;

  typedef struct packed {
    logic             valid;
    logic [PTR_W-1:0] ptr;
    logic [TAG_W-1:0] tag;
    logic             dstValid;
  } IssueWakeupStage;

endpackage

// File: rtl/issue_wakeup_pipeline_if.sv
// Grant and wakeup/release bundle between the select logic (master) and the
// issue/wakeup pipeline (slave).
interface issue_wakeup_pipeline_if #(
  parameter int ISSUE_W   = 5,
  parameter int ENTRY_NUM = 16,
  parameter int TAG_W     = 7,
  parameter int LOAD_W    = 1
);
  localparam int PTR_W = $clog2(ENTRY_NUM);

  logic [ISSUE_W-1:0]             selected;
  logic [ISSUE_W-1:0][PTR_W-1:0]  selectedPtr;
  logic [ISSUE_W-1:0][TAG_W-1:0]  dstTag;
  logic [ISSUE_W-1:0]             dstValid;
  logic                           flush;
  logic [LOAD_W-1:0]              loadCancel;
  logic [ISSUE_W-1:0]             wakeupValid;
  logic [ISSUE_W-1:0][TAG_W-1:0]  wakeupTag;
  logic [ENTRY_NUM-1:0]           releaseVector;
  logic [ENTRY_NUM-1:0]           replayVector;
  logic [ENTRY_NUM-1:0]           inflightVector;
  logic                           busy;

  modport master (
    output selected, selectedPtr, dstTag, dstValid, flush, loadCancel,
    input  wakeupValid, wakeupTag, releaseVector, replayVector, inflightVector, busy
  );

  modport slave (
    input  selected, selectedPtr, dstTag, dstValid, flush, loadCancel,
    output wakeupValid, wakeupTag, releaseVector, replayVector, inflightVector, busy
  );

endinterface

// File: rtl/issue_wakeup_pipeline_delay_line.sv
// Fixed-depth grant shift register for one issue port; exposes the final stage
// and a one-hot-OR mask of every entry it currently holds.
module wakeup_delay_line #(
  parameter int DEPTH     = 1,
  parameter int ENTRY_NUM = 16
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      flush,
  input  issue_wakeup_pipeline_pkg::IssueWakeupStage grant,
  output issue_wakeup_pipeline_pkg::IssueWakeupStage finalStage,
  output logic [ENTRY_NUM-1:0]                      inflightMask,
  output logic                                      anyValid
);
  import issue_wakeup_pipeline_pkg::*;

  logic [DEPTH-1:0] vld;
  logic [PTR_W-1:0] ptrStage [DEPTH];
  logic [TAG_W-1:0] tagStage [DEPTH];
  logic [DEPTH-1:0] dstStage;

  // Stage valids: the only state that reset and flush touch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
    end else if (flush) begin
      vld <= '0;
    end else begin
      vld[0] <= grant.valid;
      for (int k = 1; k < DEPTH; k++) vld[k] <= vld[k-1];
    end
  end

  // Payload advances unconditionally; it is only ever observed under its valid.
  always_ff @(posedge clk) begin
    ptrStage[0] <= grant.ptr;
    tagStage[0] <= grant.tag;
    dstStage[0] <= grant.dstValid;
    for (int k = 1; k < DEPTH; k++) begin
      ptrStage[k] <= ptrStage[k-1];
      tagStage[k] <= tagStage[k-1];
      dstStage[k] <= dstStage[k-1];
    end
  end

  always_comb begin
    inflightMask = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (vld[k]) inflightMask[ptrStage[k]] = 1'b1;
    end
  end

  assign finalStage = '{valid:    vld[DEPTH-1],
                        ptr:      ptrStage[DEPTH-1],
                        tag:      tagStage[DEPTH-1],
                        dstValid: dstStage[DEPTH-1]};
  assign anyValid   = |vld;

endmodule

// File: rtl/issue_wakeup_pipeline.sv
// Holds each granted op for its port-class latency, then broadcasts its tag and
// frees (or, on a load miss, replays) its issue-queue entry.
module issue_wakeup_pipeline #(
  parameter int ENTRY_NUM = issue_wakeup_pipeline_pkg::ENTRY_NUM,
  parameter int INT_W     = issue_wakeup_pipeline_pkg::INT_W,
  parameter int COMP_W    = issue_wakeup_pipeline_pkg::COMP_W,
  parameter int LOAD_W    = issue_wakeup_pipeline_pkg::LOAD_W,
  parameter int STORE_W   = issue_wakeup_pipeline_pkg::STORE_W,
  parameter int TAG_W     = issue_wakeup_pipeline_pkg::TAG_W,
  parameter int COMP_LAT  = issue_wakeup_pipeline_pkg::COMP_LAT,
  parameter int LOAD_LAT  = issue_wakeup_pipeline_pkg::LOAD_LAT
) (
  input logic                     clk,
  input logic                     rst_n,
  issue_wakeup_pipeline_if.slave  bus
);
  localparam int ISSUE_W = INT_W + COMP_W + LOAD_W + STORE_W;

  import issue_wakeup_pipeline_pkg::*;

  localparam logic [ISSUE_W-1:0] STORE_MASK = ISSUE_W'((1 << STORE_W) - 1) << STORE_BASE;

  IssueWakeupStage      grantStage [ISSUE_W];
  IssueWakeupStage      finalStage [ISSUE_W];
  logic [ENTRY_NUM-1:0] portMask   [ISSUE_W];
  logic [ISSUE_W-1:0]   portBusy;
  logic [ISSUE_W-1:0]   cancelLane;

  for (genvar p = 0; p < ISSUE_W; p++) begin : gPort
    localparam int DEPTH = (p >= STORE_BASE) ? 1 :
                           (p >= LOAD_BASE)  ? LOAD_LAT :
                           (p >= COMP_BASE)  ? COMP_LAT : 1;

    // Grants coinciding with a flush are dropped at the pipeline entrance.
    assign grantStage[p] = '{valid:    bus.selected[p] & ~bus.flush,
                             ptr:      bus.selectedPtr[p],
                             tag:      bus.dstTag[p],
                             dstValid: bus.dstValid[p]};

    wakeup_delay_line #(.DEPTH(DEPTH), .ENTRY_NUM(ENTRY_NUM)) uLine (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (bus.flush),
      .grant        (grantStage[p]),
      .finalStage   (finalStage[p]),
      .inflightMask (portMask[p]),
      .anyValid     (portBusy[p])
    );
  end

  assign cancelLane = ISSUE_W'(bus.loadCancel) << LOAD_BASE;

  // Final-stage decode: a cancelled load neither wakes up nor releases; flush
  // leaves wakeups visible but masks entry release/replay.
  always_comb begin
    bus.wakeupValid    = '0;
    bus.wakeupTag      = '0;
    bus.releaseVector  = '0;
    bus.replayVector   = '0;
    bus.inflightVector = '0;
    for (int p = 0; p < ISSUE_W; p++) begin
      if (finalStage[p].valid) begin
        if (!STORE_MASK[p] && !cancelLane[p] && finalStage[p].dstValid) begin
          bus.wakeupValid[p] = 1'b1;
          bus.wakeupTag[p]   = finalStage[p].tag;
        end
        if (!bus.flush) begin
          if (cancelLane[p]) bus.replayVector[finalStage[p].ptr]  = 1'b1;
          else               bus.releaseVector[finalStage[p].ptr] = 1'b1;
        end
      end
      bus.inflightVector = bus.inflightVector | portMask[p];
    end
  end

  assign bus.busy = |portBusy;

endmodule
